// File: rtl/fec_pkg.sv
// Shared FEC-side types: command/opcode encodings, UART parser error codes and parser states.
package fec_pkg;

  typedef enum logic [3:0] {
    CMD_REG_READ  = 4'h0,
    CMD_REG_WRITE = 4'h2,
    CMD_TX_MSG    = 4'h4
  } command_t;

  typedef enum logic {
    REG_READ  = 1'b0,
    REG_WRITE = 1'b1
  } register_op;

  typedef enum logic [2:0] {
    UART_RX_OK             = 3'd0,
    UART_RX_RTO_COMMAND    = 3'd1,
    UART_RX_RTO_MSG_LENGHT = 3'd2,
    UART_RX_RTO_MSG_TAG    = 3'd3,
    UART_RX_RTO_DATA       = 3'd4,
    UART_RX_RTO_DATA_BITS  = 3'd5,
    UART_RX_FER            = 3'd6
  } uart_error_t;

  typedef enum logic [2:0] {
    PS_IDLE,
    PS_ADDR,
    PS_WDATA,
    PS_LEN,
    PS_TAG,
    PS_PAYLOAD,
    PS_REG_ISSUE,
    PS_ERR
  } parser_state_t;

  localparam int RTO_CYCLES    = 1024;
  localparam int MAX_MSG_BYTES = 7;

endpackage

// File: rtl/fec_uart_cmd_parser_if.sv
// Bundle of RX byte stream, register request, DL payload stream and error report around the parser.
interface fec_uart_cmd_parser_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int WDATA_W = 32
);
  logic [DATA_W-1:0]  rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               rx_fer;

  logic               reg_req_valid;
  logic               reg_req_ready;
  logic               reg_req_op;
  logic [ADDR_W-1:0]  reg_req_addr;
  logic [WDATA_W-1:0] reg_req_wdata;

  logic               msg_valid;
  logic               msg_ready;
  logic [7:0]         msg_data;
  logic [7:0]         msg_tag;
  logic [3:0]         msg_len;
  logic               msg_last;

  logic               err_valid;
  logic [2:0]         err_code;

  // master: the parser itself; slave: FIFO, APB master, DL datapath and response builder
  modport master (
    input  rx_data, rx_valid, rx_fer, reg_req_ready, msg_ready,
    output rx_ready, reg_req_valid, reg_req_op, reg_req_addr, reg_req_wdata,
    output msg_valid, msg_data, msg_tag, msg_len, msg_last, err_valid, err_code
  );

  modport slave (
    output rx_data, rx_valid, rx_fer, reg_req_ready, msg_ready,
    input  rx_ready, reg_req_valid, reg_req_op, reg_req_addr, reg_req_wdata,
    input  msg_valid, msg_data, msg_tag, msg_len, msg_last, err_valid, err_code
  );
endinterface

// File: rtl/fec_rto_counter.sv
// Inter-byte receive timeout: counts enabled cycles, expires on the RTO_CYCLES-th one.
module fec_rto_counter #(
  parameter int RTO_CYCLES = 1024,
  parameter int RTO_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [RTO_W-1:0] TC = RTO_W'(RTO_CYCLES - 1);

  logic [RTO_W-1:0] cnt_q;

  assign expire = en && (cnt_q == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || expire) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/fec_uart_cmd_parser.sv
// UART command parser: frames RX FIFO bytes into register requests and DL payload streams.
// state     | meaning
// IDLE      | waiting for command byte
// ADDR      | waiting for register address byte
// WDATA     | collecting write data bytes, LSB first
// LEN       | waiting for message length byte
// TAG       | waiting for message tag byte
// PAYLOAD   | passing payload bytes straight to the DL datapath
// REG_ISSUE | holding the register request until the APB master takes it
// ERR       | one-cycle error report
module fec_uart_cmd_parser #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int WDATA_W       = 32,
  parameter int MAX_MSG_BYTES = fec_pkg::MAX_MSG_BYTES,
  parameter int RTO_CYCLES    = fec_pkg::RTO_CYCLES,
  parameter int RTO_W         = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  fec_uart_cmd_parser_if.master bus
);
  import fec_pkg::*;

  localparam int WBYTES = WDATA_W / 8;

  parser_state_t      state_q, state_d;
  uart_error_t        err_q, err_d;
  register_op         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WDATA_W-1:0] wdata_q;
  logic [7:0]         tag_q;
  logic [3:0]         len_q;
  logic [3:0]         rem_q;
  logic [3:0]         bcnt_q;
  logic               run_q;
  logic [DATA_W-1:0]  rx_byte;
  logic               rx_ready_d;
  logic               rx_accept;
  logic               timed;
  logic               rto_expire;
  logic               cmd_ok;
  logic               len_ok;

  assign rx_byte = bus.rx_data;
  assign cmd_ok  = (rx_byte[7:4] == 4'h0) &&
                   ((rx_byte[3:0] == CMD_REG_READ) || (rx_byte[3:0] == CMD_REG_WRITE));
  assign len_ok  = (rx_byte != 8'd0) && (rx_byte <= 8'(MAX_MSG_BYTES));

  // rx_ready is held low for the first cycle after reset so every output is 0 during reset
  assign bus.rx_ready = rx_ready_d && run_q;
  assign rx_accept    = bus.rx_valid && bus.rx_ready;

  assign timed = (state_q == PS_ADDR) || (state_q == PS_WDATA) || (state_q == PS_LEN) ||
                 (state_q == PS_TAG)  || (state_q == PS_PAYLOAD);

  fec_rto_counter #(
    .RTO_CYCLES (RTO_CYCLES),
    .RTO_W      (RTO_W)
  ) u_rto (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_accept || !timed),
    .en     (timed && !bus.rx_valid),
    .expire (rto_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_IDLE;
      err_q   <= UART_RX_OK;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    rx_ready_d    = 1'b0;
    bus.msg_valid = 1'b0;
    bus.msg_data  = 8'h00;
    bus.msg_last  = 1'b0;
    case (state_q)
      PS_IDLE: begin
        rx_ready_d = 1'b1;
        if (rx_accept) begin
          if (bus.rx_fer) begin
            state_d = PS_ERR;
            err_d   = UART_RX_FER;
          end else if (cmd_ok) begin
            state_d = PS_ADDR;
          end else if (rx_byte == 8'(CMD_TX_MSG)) begin
            state_d = PS_LEN;
          end else begin
            state_d = PS_ERR;
            err_d   = UART_RX_RTO_COMMAND;
          end
        end
      end
      PS_ADDR: begin
        rx_ready_d = 1'b1;
        if (rx_accept) begin
          if (bus.rx_fer) begin
            state_d = PS_ERR;
            err_d   = UART_RX_FER;
          end else begin
            state_d = (op_q == REG_WRITE) ? PS_WDATA : PS_REG_ISSUE;
          end
        end else if (rto_expire) begin
          state_d = PS_ERR;
          err_d   = UART_RX_RTO_COMMAND;
        end
      end
      PS_WDATA: begin
        rx_ready_d = 1'b1;
        if (rx_accept) begin
          if (bus.rx_fer) begin
            state_d = PS_ERR;
            err_d   = UART_RX_FER;
          end else if (bcnt_q == 4'(WBYTES - 1)) begin
            state_d = PS_REG_ISSUE;
          end
        end else if (rto_expire) begin
          state_d = PS_ERR;
          err_d   = UART_RX_RTO_DATA_BITS;
        end
      end
      PS_LEN: begin
        rx_ready_d = 1'b1;
        if (rx_accept) begin
          if (bus.rx_fer) begin
            state_d = PS_ERR;
            err_d   = UART_RX_FER;
          end else if (len_ok) begin
            state_d = PS_TAG;
          end else begin
            state_d = PS_ERR;
            err_d   = UART_RX_RTO_MSG_LENGHT;
          end
        end else if (rto_expire) begin
          state_d = PS_ERR;
          err_d   = UART_RX_RTO_MSG_LENGHT;
        end
      end
      PS_TAG: begin
        rx_ready_d = 1'b1;
        if (rx_accept) begin
          if (bus.rx_fer) begin
            state_d = PS_ERR;
            err_d   = UART_RX_FER;
          end else begin
            state_d = PS_PAYLOAD;
          end
        end else if (rto_expire) begin
          state_d = PS_ERR;
          err_d   = UART_RX_RTO_MSG_TAG;
        end
      end
      PS_PAYLOAD: begin
        // a byte with a framing error is swallowed here instead of reaching the datapath
        if (bus.rx_valid && bus.rx_fer) begin
          rx_ready_d = 1'b1;
          if (run_q) begin
            state_d = PS_ERR;
            err_d   = UART_RX_FER;
          end
        end else begin
          rx_ready_d    = bus.msg_ready;
          bus.msg_valid = bus.rx_valid;
          bus.msg_data  = bus.rx_valid ? rx_byte : 8'h00;
          bus.msg_last  = bus.rx_valid && (rem_q == 4'd1);
          if (rx_accept && (rem_q == 4'd1)) begin
            state_d = PS_IDLE;
          end else if (rto_expire) begin
            state_d = PS_ERR;
            err_d   = UART_RX_RTO_DATA;
          end
        end
      end
      PS_REG_ISSUE: begin
        if (bus.reg_req_ready) begin
          state_d = PS_IDLE;
        end
      end
      PS_ERR: begin
        state_d = PS_IDLE;
      end
      default: begin
        state_d = PS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= REG_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= 8'h00;
      len_q   <= 4'd0;
      rem_q   <= 4'd0;
      bcnt_q  <= 4'd0;
    end else if (rx_accept && !bus.rx_fer) begin
      case (state_q)
        PS_IDLE: begin
          op_q    <= (rx_byte[3:0] == CMD_REG_WRITE) ? REG_WRITE : REG_READ;
          wdata_q <= '0;
          bcnt_q  <= 4'd0;
        end
        PS_ADDR:  addr_q <= ADDR_W'(rx_byte);
        PS_WDATA: begin
          wdata_q <= {rx_byte, wdata_q[WDATA_W-1:8]};
          bcnt_q  <= bcnt_q + 4'd1;
        end
        PS_LEN: begin
          if (len_ok) begin
            len_q <= rx_byte[3:0];
            rem_q <= rx_byte[3:0];
          end
        end
        PS_TAG:     tag_q <= rx_byte;
        PS_PAYLOAD: rem_q <= rem_q - 4'd1;
        default: begin
        end
      endcase
    end
  end

  assign bus.reg_req_valid = (state_q == PS_REG_ISSUE);
  assign bus.reg_req_op    = op_q;
  assign bus.reg_req_addr  = addr_q;
  assign bus.reg_req_wdata = wdata_q;
  assign bus.msg_tag       = tag_q;
  assign bus.msg_len       = len_q;
  assign bus.err_valid     = (state_q == PS_ERR);
  assign bus.err_code      = (state_q == PS_ERR) ? err_q : 3'd0;
endmodule

// File: tb/tb_fec_uart_cmd_parser.sv
// Directed bench for fec_uart_cmd_parser: frame table plus hand-written timeout/FER/reset sequences.
module tb_fec_uart_cmd_parser;
  localparam int RTO = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fec_uart_cmd_parser_if #(.DATA_W(8), .ADDR_W(8), .WDATA_W(32)) bus ();

  fec_uart_cmd_parser #(
    .DATA_W(8), .ADDR_W(8), .WDATA_W(32), .MAX_MSG_BYTES(7), .RTO_CYCLES(RTO), .RTO_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          nb;
    logic [47:0] b;
    logic        is_err;
    logic [2:0]  code;
    logic        op;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          dly;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // called at posedge+1; returns at posedge+1 right after the byte has been accepted
  task automatic send_byte(input logic [7:0] b, input logic fer);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.rx_fer   = fer;
    @(negedge clk);
    while (!bus.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte: rx_ready never rose for byte 0x%0h", b);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_fer   = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  // called right after the last frame byte; checks latency, stability and the handshake
  task automatic check_req(input string nm, input logic op, input logic [7:0] addr,
                           input logic [31:0] wdata, input int dly);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bus.reg_req_valid), 32'd1);
    chk({nm, "_op"}, 32'(bus.reg_req_op), 32'(op));
    chk({nm, "_addr"}, 32'(bus.reg_req_addr), 32'(addr));
    chk({nm, "_wdata"}, bus.reg_req_wdata, wdata);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(bus.reg_req_valid), 32'd1);
      chk({nm, "_hold_addr"}, 32'(bus.reg_req_addr), 32'(addr));
      chk({nm, "_hold_wdata"}, bus.reg_req_wdata, wdata);
      chk({nm, "_hold_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    end
    bus.reg_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_req_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_done_valid"}, 32'(bus.reg_req_valid), 32'd0);
    chk({nm, "_done_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_err(input string nm, input logic [2:0] code);
    @(negedge clk);
    chk({nm, "_err_valid"}, 32'(bus.err_valid), 32'd1);
    chk({nm, "_err_code"}, 32'(bus.err_code), 32'(code));
    chk({nm, "_err_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    @(negedge clk);
    chk({nm, "_err_pulse_end"}, 32'(bus.err_valid), 32'd0);
    chk({nm, "_err_no_req"}, 32'(bus.reg_req_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [47:0] fb;
  logic [7:0]  pl_bytes [3];
  int          pl_stall [3];
  int          seen;
  int          n;
  int          found;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.rx_data       = 8'h00;
    bus.rx_valid      = 1'b0;
    bus.rx_fer        = 1'b0;
    bus.reg_req_ready = 1'b0;
    bus.msg_ready     = 1'b0;

    vecs[0] = '{2, {8'h00, 8'h24, 32'h0}, 1'b0, 3'd0, 1'b0, 8'h24, 32'h0, 3};
    vecs[1] = '{6, {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 1'b0, 3'd0, 1'b1, 8'h00, 32'h12345678, 0};
    vecs[2] = '{2, {8'h04, 8'h08, 32'h0}, 1'b1, 3'd2, 1'b0, 8'h00, 32'h0, 0};
    vecs[3] = '{2, {8'h00, 8'h20, 32'h0}, 1'b0, 3'd0, 1'b0, 8'h20, 32'h0, 0};
    vecs[4] = '{1, {8'h0F, 40'h0}, 1'b1, 3'd1, 1'b0, 8'h00, 32'h0, 0};
    vecs[5] = '{1, {8'h10, 40'h0}, 1'b1, 3'd1, 1'b0, 8'h00, 32'h0, 0};
    vecs[6] = '{2, {8'h04, 8'h00, 32'h0}, 1'b1, 3'd2, 1'b0, 8'h00, 32'h0, 0};
    vecs[7] = '{6, {8'h02, 8'hAB, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, 3'd0, 1'b1, 8'hAB, 32'h04030201, 1};

    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_reg_req_valid", 32'(bus.reg_req_valid), 32'd0);
    chk("rst_msg_valid", 32'(bus.msg_valid), 32'd0);
    chk("rst_err_valid", 32'(bus.err_valid), 32'd0);
    chk("rst_msg_len_tag", {16'h0, bus.msg_len, 4'h0, bus.msg_tag}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // IDLE never times out
    seen = 0;
    repeat (2 * RTO + 4) begin
      @(negedge clk);
      if (bus.err_valid) seen++;
    end
    chk("idle_no_rto", 32'(seen), 32'd0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      fb = vecs[v].b;
      for (int i = 0; i < vecs[v].nb; i++) send_byte(fb[47-8*i -: 8], 1'b0);
      if (vecs[v].is_err) check_err($sformatf("vec%0d", v), vecs[v].code);
      else check_req($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].wdata, vecs[v].dly);
    end

    // TX_MSG with msg_ready stalls longer than the timeout
    send_byte(8'h04, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hA5, 1'b0);
    pl_bytes[0] = 8'h11; pl_bytes[1] = 8'h22; pl_bytes[2] = 8'h33;
    pl_stall[0] = 1;     pl_stall[1] = RTO + 4; pl_stall[2] = 2;
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid  = 1'b1;
      bus.rx_data   = pl_bytes[i];
      bus.msg_ready = 1'b0;
      seen = 0;
      for (int s = 0; s < pl_stall[i]; s++) begin
        @(negedge clk);
        if (!bus.msg_valid || bus.rx_ready || bus.err_valid) seen++;
      end
      chk($sformatf("msg_stall%0d", i), 32'(seen), 32'd0);
      bus.msg_ready = 1'b1;
      #1;
      chk($sformatf("msg_data%0d", i), 32'(bus.msg_data), 32'(pl_bytes[i]));
      chk($sformatf("msg_last%0d", i), 32'(bus.msg_last), (i == 2) ? 32'd1 : 32'd0);
      chk($sformatf("msg_rx_ready%0d", i), 32'(bus.rx_ready), 32'd1);
      chk($sformatf("msg_tag%0d", i), 32'(bus.msg_tag), 32'hA5);
      chk($sformatf("msg_len%0d", i), 32'(bus.msg_len), 32'd3);
      @(posedge clk);
      #1;
    end
    bus.rx_valid  = 1'b0;
    bus.msg_ready = 1'b0;
    @(negedge clk);
    chk("msg_end_valid", 32'(bus.msg_valid), 32'd0);
    chk("msg_end_data", 32'(bus.msg_data), 32'd0);
    chk("msg_end_idle", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;

    // WDATA timeout: exactly RTO idle cycles after the last accepted byte
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    n = 0; found = 0; seen = 0;
    while (!found && n < RTO + 8) begin
      @(negedge clk);
      n++;
      if (bus.reg_req_valid) seen++;
      if (bus.err_valid) found = 1;
    end
    chk("wdata_rto_found", 32'(found), 32'd1);
    chk("wdata_rto_cycles", 32'(n), 32'(RTO + 1));
    chk("wdata_rto_code", 32'(bus.err_code), 32'd5);
    chk("wdata_rto_no_req", 32'(seen), 32'd0);
    @(posedge clk);
    #1;

    // PAYLOAD timeout: truncated message, msg_last never asserted
    send_byte(8'h04, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h33, 1'b0);
    bus.msg_ready = 1'b1;
    send_byte(8'h44, 1'b0);
    n = 0; found = 0; seen = 0;
    while (!found && n < RTO + 8) begin
      @(negedge clk);
      n++;
      if (bus.msg_last || bus.msg_valid) seen++;
      if (bus.err_valid) found = 1;
    end
    chk("pl_rto_found", 32'(found), 32'd1);
    chk("pl_rto_code", 32'(bus.err_code), 32'd4);
    chk("pl_rto_no_last", 32'(seen), 32'd0);
    bus.msg_ready = 1'b0;
    @(posedge clk);
    #1;

    // framing error on the address byte of a read
    send_byte(8'h00, 1'b0);
    send_byte(8'h24, 1'b1);
    check_err("fer", 3'd6);

    // reset during PAYLOAD: everything drops at once, no error afterwards
    send_byte(8'h04, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h77, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    @(negedge clk);
    chk("rstpl_pre_valid", 32'(bus.msg_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstpl_msg_valid", 32'(bus.msg_valid), 32'd0);
    chk("rstpl_msg_data", 32'(bus.msg_data), 32'd0);
    chk("rstpl_len_tag", {16'h0, bus.msg_len, 4'h0, bus.msg_tag}, 32'd0);
    chk("rstpl_rx_ready", 32'(bus.rx_ready), 32'd0);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (2 * RTO + 4) begin
      @(negedge clk);
      if (bus.err_valid) seen++;
    end
    chk("rstpl_no_err", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    check_req("post_rst", 1'b0, 8'h5A, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
